// File: rtl/wrr_mq_fifo.sv
// Multi-queue packet buffer: NQ circular FIFOs drained by a run-time selectable
// weighted-round-robin or strict-priority scheduler into a registered egress stage.
module wrr_mq_fifo #(
    parameter int DATA_W = 16,
    parameter int NQ     = 8,
    parameter int QID_W  = 3,
    parameter int ADDR_W = 3,
    parameter int WGT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [QID_W-1:0]  in_prior,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [QID_W-1:0]  out_qid,
    input  logic              sp_mode,
    input  logic              wgt_we,
    input  logic [QID_W-1:0]  wgt_sel,
    input  logic [WGT_W-1:0]  wgt_data,
    output logic [NQ-1:0]     q_full,
    output logic [NQ-1:0]     q_empty,
    output logic [15:0]       drop_cnt
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, SERVE} state_t;

    logic [DATA_W-1:0] r_mem [NQ][DEPTH];
    logic [ADDR_W:0]   r_wr  [NQ];
    logic [ADDR_W:0]   r_rd  [NQ];
    logic [WGT_W-1:0]  r_wgt [NQ];

    state_t            r_state, w_state_nxt;
    logic [QID_W-1:0]  r_cur, w_cur_nxt, w_cur_inc, w_pop_q, w_idx;
    logic [WGT_W-1:0]  r_cred, w_cred_nxt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [QID_W-1:0]  r_out_qid;
    logic [15:0]       r_drop;

    logic [NQ-1:0]     w_empty, w_full;
    logic              w_push, w_pop, w_out_free, w_last, w_found;
    logic [ADDR_W:0]   w_cnt_cur;

    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int q = 0; q < NQ; q++) begin
            w_empty[q] = (r_wr[q] == r_rd[q]);
            w_full[q]  = (r_wr[q][ADDR_W-1:0] == r_rd[q][ADDR_W-1:0]) &&
                         (r_wr[q][ADDR_W] != r_rd[q][ADDR_W]);
        end
    end

    assign in_ready   = !w_full[in_prior];
    assign w_push     = in_valid && in_ready;
    assign w_out_free = !r_out_valid || out_ready;
    assign w_cur_inc  = (r_cur == QID_W'(NQ-1)) ? '0 : r_cur + QID_W'(1);
    assign w_cnt_cur  = r_wr[r_cur] - r_rd[r_cur];
    // A push landing on cur in the same cycle keeps the grant alive.
    assign w_last     = (w_cnt_cur == (ADDR_W+1)'(1)) && !(w_push && in_prior == r_cur);

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_cred_nxt  = r_cred;
        w_pop       = 1'b0;
        w_pop_q     = r_cur;
        w_found     = 1'b0;
        w_idx       = '0;
        case (r_state)
            IDLE: begin
                if (sp_mode) begin
                    for (int i = 0; i < NQ; i++) begin
                        if (!w_empty[i]) begin
                            w_pop_q = QID_W'(i);
                            w_found = 1'b1;
                        end
                    end
                    w_pop = w_found && w_out_free;
                end else begin
                    // Walk from the far end so the nearest eligible queue wins.
                    for (int i = NQ-1; i >= 0; i--) begin
                        w_idx = QID_W'((int'(r_cur) + i) % NQ);
                        if (!w_empty[w_idx] && r_wgt[w_idx] != '0) begin
                            w_cur_nxt   = w_idx;
                            w_cred_nxt  = r_wgt[w_idx];
                            w_state_nxt = SERVE;
                        end
                    end
                end
            end
            SERVE: begin
                if (w_empty[r_cur]) begin
                    w_state_nxt = IDLE;
                    w_cur_nxt   = w_cur_inc;
                end else if (w_out_free) begin
                    w_pop      = 1'b1;
                    w_cred_nxt = r_cred - WGT_W'(1);
                    if (r_cred == WGT_W'(1) || w_last) begin
                        w_state_nxt = IDLE;
                        w_cur_nxt   = w_cur_inc;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[in_prior][r_wr[in_prior][ADDR_W-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NQ; q++) begin
                r_wr[q]  <= '0;
                r_rd[q]  <= '0;
                r_wgt[q] <= (q + 1 >= 2**WGT_W) ? WGT_W'(2**WGT_W - 1) : WGT_W'(q + 1);
            end
            r_state     <= IDLE;
            r_cur       <= '0;
            r_cred      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_qid   <= '0;
            r_drop      <= '0;
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (w_push && in_prior == QID_W'(q))
                    r_wr[q] <= r_wr[q] + (ADDR_W+1)'(1);
                if (w_pop && w_pop_q == QID_W'(q))
                    r_rd[q] <= r_rd[q] + (ADDR_W+1)'(1);
            end
            if (wgt_we)
                r_wgt[wgt_sel] <= wgt_data;
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_cred  <= w_cred_nxt;
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[w_pop_q][r_rd[w_pop_q][ADDR_W-1:0]];
                r_out_qid   <= w_pop_q;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (in_valid && !in_ready && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_qid   = r_out_qid;
    assign q_full    = w_full;
    assign q_empty   = w_empty;
    assign drop_cnt  = r_drop;
endmodule
